// File: rtl/irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl
//
// Rising-edge interrupt capture with fixed priority presentation.
// Each of the 8 request lines is edge-detected against its value at the
// previous clock edge. Edges set a sticky pending bit. Unmasked pending bits
// compete by priority, with bit 7 highest. The winner is latched and presented
// until the consumer acknowledges it.
//
// Handshake: irq_valid/irq_id form a valid/ack pair. Once irq_valid=1, irq_id
// stays stable. A higher-priority arrival does not pre-empt it, and setting
// its mask bit does not withdraw it. It stays until a rising edge of clk that
// samples irq_ack=1. That edge retires the index and clears its pending bit.
// irq_ack is ignored while irq_valid=0.
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   irq_in     raw request lines [7:0]
//   mask       mask[i]=1 keeps line i from being presented; it still pends
//   irq_ack    acknowledge of the presented index
//   irq_valid  an index is being presented (registered)
//   irq_id     presented index, binary encoded (registered)
//   pending    pending-request vector (registered)
//   dbg_state  current FSM state, 0=IDLE 1=PRESENT, for observation
// -----------------------------------------------------------------------------
module irq_priority_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_prev;
  logic [7:0] r_pending;
  logic [2:0] r_id;
  logic       r_valid;

  logic [7:0] w_rise;
  logic [7:0] w_elig;
  logic [7:0] w_clr;
  logic [2:0] w_top;

  assign w_rise = irq_in & ~r_prev;
  assign w_elig = r_pending & ~mask;

  // Only an acknowledged presentation clears a bit. The rise term is ORed in
  // afterwards, so a new edge on the same line at the same edge wins.
  always_comb begin
    w_clr = 8'h00;
    if (r_state == PRESENT && irq_ack) begin
      w_clr[r_id] = 1'b1;
    end
  end

  // Highest set bit of w_elig. The ascending loop lets higher indices
  // overwrite lower ones.
  always_comb begin
    w_top = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_elig[i]) begin
        w_top = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Capturing irq_in during reset means lines already high at release
      // do not produce edges.
      r_prev    <= irq_in;
      r_pending <= 8'h00;
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_id      <= 3'd0;
    end else begin
      r_prev    <= irq_in;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      case (r_state)
        IDLE: begin
          if (w_elig != 8'h00) begin
            r_id    <= w_top;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = r_valid;
  assign irq_id    = r_id;
  assign pending   = r_pending;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for irq_priority_ctrl.
// Directed scenarios carry hand-computed literal expectations. A randomized
// phase follows. A behavioural model is compared against the DUT on every
// cycle.
// -----------------------------------------------------------------------------
module tb_irq_priority_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       irq_ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       dbg_state;

  always #5 clk = ~clk;

  irq_priority_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // ---------------- behavioural model ----------------
  logic [7:0] m_prev    = 8'h00;
  logic [7:0] m_pending = 8'h00;
  logic       m_valid   = 1'b0;
  logic [2:0] m_id      = 3'd0;

  always @(posedge clk) begin
    logic [7:0] nxt;
    logic [7:0] elig;
    int         hi;
    if (rst) begin
      m_pending = 8'h00;
      m_valid   = 1'b0;
      m_id      = 3'd0;
    end else begin
      nxt = m_pending;
      if (m_valid && irq_ack) nxt[m_id] = 1'b0;
      for (int i = 0; i < 8; i++)
        if (irq_in[i] && !m_prev[i]) nxt[i] = 1'b1;
      if (!m_valid) begin
        elig = m_pending & ~mask;
        hi = -1;
        for (int i = 0; i < 8; i++) if (elig[i]) hi = i;
        if (hi >= 0) begin
          m_valid = 1'b1;
          m_id    = 3'(hi);
        end
      end else if (irq_ack) begin
        m_valid = 1'b0;
      end
      m_pending = nxt;
    end
    m_prev = irq_in;
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model_valid", {7'd0, irq_valid}, {7'd0, m_valid});
      chk("model_pending", pending, m_pending);
      chk("model_state", {7'd0, dbg_state}, {7'd0, m_valid});
      if (m_valid) chk("model_id", {5'd0, irq_id}, {5'd0, m_id});
    end
  end

  // ---------------- driver ----------------
  // Applies inputs, waits for the sampling edge, and returns shortly after
  // the edge so that outputs are settled.
  task automatic step(input logic r, input logic [7:0] in, input logic [7:0] m,
                      input logic a);
    rst     = r;
    irq_in  = in;
    mask    = m;
    irq_ack = a;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic v, input logic [2:0] id,
                     input logic [7:0] p);
    chk({name, "_valid"}, {7'd0, irq_valid}, {7'd0, v});
    if (v) chk({name, "_id"}, {5'd0, irq_id}, {5'd0, id});
    chk({name, "_pending"}, pending, p);
  endtask

  int pres_cnt;
  logic last_v;

  initial begin
    // reset
    step(1, 8'h00, 8'h00, 0);
    step(1, 8'h00, 8'h00, 0);
    chk_en = 1'b1;
    lit("reset", 0, 0, 8'h00);
    chk("reset_id", {5'd0, irq_id}, 8'h00);
    step(0, 8'h00, 8'h00, 0);

    // simultaneous arrivals 00 -> A4
    step(0, 8'hA4, 8'h00, 0);
    lit("arrive", 0, 0, 8'hA4);
    step(0, 8'h00, 8'h00, 0);
    lit("first_pres", 1, 7, 8'hA4);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 8'h00, 0);
    lit("hold5", 1, 7, 8'hA4);

    // ordered servicing 7,5,2
    step(0, 8'h00, 8'h00, 1);
    lit("ack7", 0, 0, 8'h24);
    step(0, 8'h00, 8'h00, 0);
    lit("pres5", 1, 5, 8'h24);
    step(0, 8'h00, 8'h00, 1);
    lit("ack5", 0, 0, 8'h04);
    step(0, 8'h00, 8'h00, 0);
    lit("pres2", 1, 2, 8'h04);
    step(0, 8'h00, 8'h00, 1);
    lit("ack2", 0, 0, 8'h00);

    // masking
    step(0, 8'h82, 8'h80, 0);
    lit("mask_arrive", 0, 0, 8'h82);
    step(0, 8'h82, 8'h80, 0);
    lit("mask_pres1", 1, 1, 8'h82);
    step(0, 8'h82, 8'h80, 1);
    lit("mask_ack1", 0, 0, 8'h80);
    step(0, 8'h82, 8'h80, 0);
    lit("mask_blocked", 0, 0, 8'h80);
    step(0, 8'h82, 8'h00, 0);
    lit("unmask_pres7", 1, 7, 8'h80);
    step(0, 8'h00, 8'h00, 1);
    lit("unmask_ack7", 0, 0, 8'h00);

    // set and ack at the same edge
    step(0, 8'h08, 8'h00, 0);
    lit("sa_arrive", 0, 0, 8'h08);
    step(0, 8'h08, 8'h00, 0);
    lit("sa_pres", 1, 3, 8'h08);
    step(0, 8'h00, 8'h00, 0);
    step(0, 8'h08, 8'h00, 1);
    lit("sa_collide", 0, 0, 8'h08);
    step(0, 8'h08, 8'h00, 0);
    lit("sa_repres", 1, 3, 8'h08);
    step(0, 8'h00, 8'h00, 1);
    lit("sa_final", 0, 0, 8'h00);

    // level ignored
    pres_cnt = 0;
    last_v   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 8'h10, 8'h00, m_valid);
      if (irq_valid && !last_v) pres_cnt++;
      last_v = irq_valid;
    end
    step(0, 8'h00, 8'h00, m_valid);
    step(0, 8'h00, 8'h00, 0);
    chk("level_once", 8'(pres_cnt), 8'd1);
    lit("level_end", 0, 0, 8'h00);

    // reset mid-PRESENT
    step(0, 8'h01, 8'h00, 0);
    step(0, 8'h01, 8'h00, 0);
    lit("pre_rst", 1, 0, 8'h01);
    step(1, 8'h01, 8'h00, 0);
    lit("rst_abort", 0, 0, 8'h00);

    // lines held high through reset release
    step(1, 8'hFF, 8'h00, 0);
    step(0, 8'hFF, 8'h00, 0);
    lit("ff_rel1", 0, 0, 8'h00);
    step(0, 8'hFF, 8'h00, 0);
    lit("ff_rel2", 0, 0, 8'h00);
    step(0, 8'h00, 8'h00, 0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] in_v;
      logic [7:0] m_v;
      in_v = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      m_v  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      step(($urandom_range(0, 99) == 0), in_v, m_v, 1'($urandom_range(0, 2) == 0));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
